// File: rtl/button_events_if.sv
// Button event bundle between the debounce stage and application logic.
// The release/repeat events carry an _evt suffix because both words are reserved in SystemVerilog.
interface button_events_if;
    logic sw_in;
    logic press;
    logic release_evt;
    logic long_press;
    logic repeat_evt;
    logic held;

    modport master (
        output sw_in,
        input  press, release_evt, long_press, repeat_evt, held
    );

    modport slave (
        input  sw_in,
        output press, release_evt, long_press, repeat_evt, held
    );
endinterface

// File: rtl/button_events.sv
// Turns a debounced button level into registered single-cycle press, release,
// long-press and auto-repeat events, plus a held level.
module button_events #(
    parameter int unsigned LONG_CYCLES   = 12000000,
    parameter int unsigned REPEAT_CYCLES = 3000000,
    parameter int unsigned CNT_W         = 24
) (
    input  logic           clk,
    input  logic           rstn,
    button_events_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESSED   = 2'd1,
        HELD_LONG = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

    state_t           state, state_nx;
    logic [CNT_W-1:0] timer, timer_nx;
    logic             sw_r;
    logic             rise, fall;

    logic press_r, release_r, long_r, repeat_r, held_r;
    logic press_nx, release_nx, long_nx, repeat_nx, held_nx;

    assign rise = bus.sw_in & ~sw_r;
    assign fall = ~bus.sw_in & sw_r;

    // NOTE: state and output registers use non-blocking assignments so every
    // flop samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            timer     <= '0;
            sw_r      <= 1'b0;
            press_r   <= 1'b0;
            release_r <= 1'b0;
            long_r    <= 1'b0;
            repeat_r  <= 1'b0;
            held_r    <= 1'b0;
        end else begin
            state     <= state_nx;
            timer     <= timer_nx;
            sw_r      <= bus.sw_in;
            press_r   <= press_nx;
            release_r <= release_nx;
            long_r    <= long_nx;
            repeat_r  <= repeat_nx;
            held_r    <= held_nx;
        end
    end

    // NOTE: every signal gets a default before the case so no path can leave
    // one unassigned and infer a latch.
    always_comb begin
        state_nx   = state;
        timer_nx   = timer;
        press_nx   = 1'b0;
        release_nx = 1'b0;
        long_nx    = 1'b0;
        repeat_nx  = 1'b0;
        held_nx    = held_r;

        unique case (state)
            IDLE: begin
                if (rise) begin
                    state_nx = PRESSED;
                    timer_nx = '0;
                    press_nx = 1'b1;
                    held_nx  = 1'b1;
                end
            end
            PRESSED: begin
                // A fall always wins over a coincident terminal count.
                if (fall) begin
                    state_nx   = IDLE;
                    timer_nx   = '0;
                    release_nx = 1'b1;
                    held_nx    = 1'b0;
                end else if (timer == LONG_LAST) begin
                    state_nx = HELD_LONG;
                    timer_nx = '0;
                    long_nx  = 1'b1;
                end else begin
                    timer_nx = timer + CNT_W'(1);
                end
            end
            HELD_LONG: begin
                if (fall) begin
                    state_nx   = IDLE;
                    timer_nx   = '0;
                    release_nx = 1'b1;
                    held_nx    = 1'b0;
                end else if (timer == REPEAT_LAST) begin
                    timer_nx  = '0;
                    repeat_nx = 1'b1;
                end else begin
                    timer_nx = timer + CNT_W'(1);
                end
            end
            default: begin
                state_nx = IDLE;
                timer_nx = '0;
                held_nx  = 1'b0;
            end
        endcase
    end

    assign bus.press       = press_r;
    assign bus.release_evt = release_r;
    assign bus.long_press  = long_r;
    assign bus.repeat_evt  = repeat_r;
    assign bus.held        = held_r;

endmodule
